// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared op encodings, sequencer states and IO address default
package mem_ctrl_pkg;
  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_ILL   = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_CAP  = 3'd2,
    S_WR      = 3'd3,
    S_ERR     = 3'd4
  } state_e;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable 3-bit down-counter that holds at zero
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [2:0] cnt_q, cnt_d;
  always_comb
    cnt_d = load ? load_val : (dec && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= 3'd0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == 3'd0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle fetch/load/store sequencer for a synchronous-read memory
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          MEM_LATENCY = 1,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  output logic        IorD,
  output logic        wea,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        io_sel,
  output logic        io_we,
  output logic        load_valid
);
  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   io_q, io_d;
  logic   accept, is_io, wait_zero;
  assign accept = req_valid && state_q == S_IDLE;
  assign is_io  = req_addr == IO_ADDR;
  mem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (3'(MEM_LATENCY - 1)),
    .dec      (state_q == S_RD_WAIT),
    .zero     (wait_zero)
  );
  always_comb begin
    state_d = state_q;
    op_d    = accept ? op_e'(req_op) : op_q;
    io_d    = accept ? is_io : io_q;
    case (state_q)
      S_IDLE:
        if (req_valid)
          case (op_e'(req_op))
            OP_FETCH: state_d = S_RD_WAIT;
            OP_LOAD:  state_d = is_io ? S_RD_CAP : S_RD_WAIT;
            OP_STORE: state_d = S_WR;
            default:  state_d = S_ERR;
          endcase
      S_RD_WAIT: state_d = wait_zero ? S_RD_CAP : S_RD_WAIT;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      io_q    <= io_d;
    end
  // Data accesses (load/store, memory or IO) are addressed by ALUout throughout.
  always_comb begin
    req_ready  = state_q == S_IDLE && reset;
    IorD       = (state_q == S_RD_WAIT || state_q == S_RD_CAP || state_q == S_WR) && op_q != OP_FETCH;
    done       = state_q == S_RD_CAP || state_q == S_WR;
    err        = state_q == S_ERR;
    IRWrite    = state_q == S_RD_CAP && op_q == OP_FETCH;
    PCWrite    = state_q == S_RD_CAP && op_q == OP_FETCH;
    load_valid = state_q == S_RD_CAP && op_q == OP_LOAD;
    io_sel     = state_q == S_RD_CAP && op_q == OP_LOAD && io_q;
    wea        = state_q == S_WR && !io_q;
    io_we      = state_q == S_WR && io_q;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random and directed stimulus on latency-1 and latency-3 instances against a per-cycle schedule model
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = 16'h0000;
  logic [9:0]  o1, o3;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  localparam logic [9:0] R = 10'h200, D = 10'h100, E = 10'h080, A = 10'h040, W = 10'h020;
  localparam logic [9:0] I = 10'h010, P = 10'h008, S = 10'h004, O = 10'h002, V = 10'h001;
  logic [9:0] mq [2][$];
  always #5 clk = ~clk;
  logic r1, d1, e1, a1, w1, i1, p1, s1, x1, v1;
  logic r3, d3, e3, a3, w3, i3, p3, s3, x3, v3;
  mem_access_ctrl #(.MEM_LATENCY(1), .IO_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_ready(r1), .done(d1), .err(e1), .IorD(a1), .wea(w1), .IRWrite(i1), .PCWrite(p1),
    .io_sel(s1), .io_we(x1), .load_valid(v1));
  mem_access_ctrl #(.MEM_LATENCY(3), .IO_ADDR(16'hFFFF)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_ready(r3), .done(d3), .err(e3), .IorD(a3), .wea(w3), .IRWrite(i3), .PCWrite(p3),
    .io_sel(s3), .io_we(x3), .load_valid(v3));
  assign o1 = {r1, d1, e1, a1, w1, i1, p1, s1, x1, v1};
  assign o3 = {r3, d3, e3, a3, w3, i3, p3, s3, x3, v3};
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [9:0] expect_now(input int k);
    if (!reset) return 10'h000;
    return mq[k].size() != 0 ? mq[k][0] : R;
  endfunction
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      int lat = k == 0 ? 1 : 3;
      if (!reset) mq[k].delete();
      else if (mq[k].size() != 0) void'(mq[k].pop_front());
      else if (req_valid)
        case (req_op)
          2'b00: begin
            for (int j = 0; j < lat; j++) mq[k].push_back(10'h000);
            mq[k].push_back(D | I | P);
          end
          2'b01:
            if (req_addr == 16'hFFFF) mq[k].push_back(A | S | V | D);
            else begin
              for (int j = 0; j < lat; j++) mq[k].push_back(A);
              mq[k].push_back(A | V | D);
            end
          2'b10: mq[k].push_back(A | D | (req_addr == 16'hFFFF ? O : W));
          default: mq[k].push_back(E);
        endcase
    end
  endtask
  task automatic cycle(input bit v, input logic [1:0] op, input logic [15:0] a);
    req_valid = v;
    req_op = op;
    req_addr = a;
    @(negedge clk);
    check("lat1", o1, expect_now(0));
    check("lat3", o3, expect_now(1));
    @(posedge clk);
    advance();
    cyc++;
    #1;
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 2'b00, 16'h0000);
  endtask
  initial begin
    idle(2);
    reset = 1'b1;
    idle(1);
    cycle(1'b1, 2'b00, 16'h0000);
    idle(6);
    cycle(1'b1, 2'b10, 16'h0005);
    idle(2);
    cycle(1'b1, 2'b01, 16'h0005);
    idle(6);
    cycle(1'b1, 2'b10, 16'hFFFF);
    idle(2);
    cycle(1'b1, 2'b01, 16'hFFFF);
    idle(2);
    cycle(1'b1, 2'b11, 16'h1234);
    idle(2);
    cycle(1'b1, 2'b01, 16'hFFFE);
    idle(6);
    cycle(1'b1, 2'b00, 16'h0000);
    idle(1);
    reset = 1'b0;
    #1;
    check("async_rst_lat1", o1, 10'h000);
    check("async_rst_lat3", o3, 10'h000);
    idle(2);
    reset = 1'b1;
    cycle(1'b1, 2'b00, 16'h0000);
    idle(6);
    for (int j = 0; j < 16; j++) cycle(1'b1, 2'b00, 16'h0000);
    idle(6);
    for (int j = 0; j < 400; j++) begin
      logic [15:0] a;
      case ($urandom_range(3))
        0: a = 16'h0005;
        1: a = 16'hFFFF;
        2: a = 16'hFFFE;
        default: a = 16'($urandom);
      endcase
      cycle($urandom_range(3) != 0, 2'($urandom_range(3)), a);
    end
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
